// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward arbiter for the 5-stage MIPS pipeline.
//
// Sits beside the four pipeline latches and the PC. It issues latch enables,
// bubble inserts, the PC write enable and the EX-stage operand selects. It
// also runs a data-memory wait watchdog and a saturating stall-cycle counter.
//
// Compile-time option:
//   HAZARD_FORWARD_EN  defined   -> only load-use RAW hazards stall; every
//                                   other dependency is resolved through
//                                   the registered fwdA/fwdB selects.
//                      undefined -> any EX or MEM RAW match stalls, and
//                                   fwdA/fwdB are tied to 2'b00.
//
// Enable/bubble contract with the pipeline latches: a latch captures its
// input on an edge where its *_EN is 1. A latch with *_NOP = 1 loads a bubble
// on that edge instead of its input. PCWE = 1 lets the PC advance on that
// edge. All of these are combinational from the current state and inputs,
// so they take effect on the same edge.
//
// dbg_state exposes the controller state (00 RUN, 01 MEMWAIT, 10 FLUSH) so
// that checkers can observe the FSM directly.

module hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             MemRd,
  input  logic             MemWr,
  input  logic [1:0]       PCSrc,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] exe_wsel,
  input  logic [REG_W-1:0] mem_wsel,
  input  logic             exe_RegWr,
  input  logic             mem_RegWr,
  input  logic             exe_MemRd,
  output logic             PCWE,
  output logic             fetch_EN,
  output logic             decode_EN,
  output logic             exe_EN,
  output logic             mem_EN,
  output logic             fetch_NOP,
  output logic             decode_NOP,
  output logic             exe_NOP,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  // Counter widths: the flush counter must hold FLUSH_CYCLES-1. The wait
  // counter must hold MEM_TIMEOUT. Both are at least one bit.
  localparam int FLUSH_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT   = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic pcsrc_taken;
  logic mem_req;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic raw_stall;

  assign pcsrc_taken = (PCSrc != 2'b00);
  assign mem_req     = MemRd | MemWr;

  // A source depends on a stage when that stage will write the same
  // register. Register 0 is hard-wired, so it never creates a dependency.
  assign rs_ex  = exe_RegWr && (rs == exe_wsel) && (rs != '0);
  assign rt_ex  = exe_RegWr && (rt == exe_wsel) && (rt != '0);
  assign rs_mem = mem_RegWr && (rs == mem_wsel) && (rs != '0);
  assign rt_mem = mem_RegWr && (rt == mem_wsel) && (rt != '0);

`ifdef HAZARD_FORWARD_EN
  // With forwarding, only a load in EX cannot supply its result in time.
  assign raw_stall = exe_MemRd && (rs_ex || rt_ex);
`else
  // Without forwarding, every in-flight writer blocks decode. The load-use
  // term is a subset of the EX term and is kept for symmetry.
  assign raw_stall = (exe_MemRd && (rs_ex || rt_ex)) || rs_ex || rt_ex ||
                     rs_mem || rt_mem;
`endif

  // Next-state and Mealy control outputs, in RUN priority order.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    PCWE        = ihit;
    fetch_EN    = 1'b0;
    decode_EN   = 1'b0;
    exe_EN      = 1'b0;
    mem_EN      = 1'b0;
    fetch_NOP   = 1'b0;
    decode_NOP  = 1'b0;
    exe_NOP     = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (pcsrc_taken) begin
          // Squash the wrong-path instructions in fetch, decode and EX.
          fetch_NOP  = 1'b1;
          decode_NOP = 1'b1;
          exe_NOP    = 1'b1;
          fetch_EN   = 1'b1;
          decode_EN  = 1'b1;
          exe_EN     = 1'b1;
          mem_EN     = 1'b1;
          PCWE       = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end
        end else if (mem_req && dhit) begin
          fetch_EN  = 1'b1;
          decode_EN = 1'b1;
          exe_EN    = 1'b1;
          mem_EN    = 1'b1;
          PCWE      = 1'b1;
        end else if (mem_req) begin
          // Freeze the whole pipe until the data memory answers.
          PCWE       = 1'b0;
          state_d    = ST_MEMWAIT;
          wait_cnt_d = '0;
        end else if (raw_stall) begin
          // Hold fetch/decode, push a bubble into EX, and let EX/MEM drain.
          PCWE       = 1'b0;
          decode_NOP = 1'b1;
          exe_EN     = 1'b1;
          mem_EN     = 1'b1;
        end else if (ihit) begin
          fetch_EN  = 1'b1;
          decode_EN = 1'b1;
          exe_EN    = 1'b1;
          mem_EN    = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        PCWE = 1'b0;
        // The wait counter saturates at the limit so it never wraps.
        if (wait_cnt_q != WAIT_LIMIT) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if ((MEM_TIMEOUT != 0) && (wait_cnt_d == WAIT_LIMIT)) begin
          timeout_d = 1'b1;
        end
        if (dhit) begin
          fetch_EN  = 1'b1;
          decode_EN = 1'b1;
          exe_EN    = 1'b1;
          mem_EN    = 1'b1;
          PCWE      = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_FLUSH: begin
        fetch_NOP  = 1'b1;
        decode_NOP = 1'b1;
        fetch_EN   = ihit;
        decode_EN  = ihit;
        exe_EN     = ihit;
        mem_EN     = ihit;
        if (pcsrc_taken) begin
          // A further redirect restarts the flush window.
          flush_cnt_d = FLUSH_RELOAD;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_d == '0) begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // While reset is held, every control output is inactive.
    if (!nRST) begin
      PCWE       = 1'b0;
      fetch_EN   = 1'b0;
      decode_EN  = 1'b0;
      exe_EN     = 1'b0;
      mem_EN     = 1'b0;
      fetch_NOP  = 1'b0;
      decode_NOP = 1'b0;
      exe_NOP    = 1'b0;
    end
  end

  // Stall-cycle counter: counts cycles where the PC is held, and saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWE && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // FSM and counter registers, asynchronously cleared.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign dbg_state   = state_q;

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  // Operand selects follow the instruction from decode into EX. A bubble
  // clears them, a frozen EX holds them, and EX beats MEM when both match.
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (decode_NOP || exe_NOP) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else if (decode_EN) begin
      fwd_a_d = rs_ex ? 2'b01 : (rs_mem ? 2'b10 : 2'b00);
      fwd_b_d = rt_ex ? 2'b01 : (rt_mem ? 2'b10 : 2'b00);
    end
  end

  // Forwarding-select registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwdA = fwd_a_q;
  assign fwdB = fwd_b_q;
`else
  assign fwdA = 2'b00;
  assign fwdB = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Two instances share one set of inputs:
//   u_a: FLUSH_CYCLES=3, MEM_TIMEOUT=64, CNT_W=16
//   u_b: FLUSH_CYCLES=1, MEM_TIMEOUT=4,  CNT_W=3 (small counter for saturation)
// The expectations follow HAZARD_FORWARD_EN when the bench is compiled with it.

module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       CLK, nRST;
  logic       ihit, dhit, MemRd, MemWr, exe_RegWr, mem_RegWr, exe_MemRd;
  logic [1:0] PCSrc;
  logic [4:0] rs, rt, exe_wsel, mem_wsel;

  logic        a_pcwe, a_fen, a_den, a_een, a_men, a_fnop, a_dnop, a_enop, a_to;
  logic [1:0]  a_fwda, a_fwdb, a_st;
  logic [15:0] a_cnt;
  logic        b_pcwe, b_fen, b_den, b_een, b_men, b_fnop, b_dnop, b_enop, b_to;
  logic [1:0]  b_fwda, b_fwdb, b_st;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(3), .MEM_TIMEOUT(64), .CNT_W(16)) u_a (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .MemRd(MemRd), .MemWr(MemWr),
    .PCSrc(PCSrc), .rs(rs), .rt(rt), .exe_wsel(exe_wsel), .mem_wsel(mem_wsel),
    .exe_RegWr(exe_RegWr), .mem_RegWr(mem_RegWr), .exe_MemRd(exe_MemRd),
    .PCWE(a_pcwe), .fetch_EN(a_fen), .decode_EN(a_den), .exe_EN(a_een), .mem_EN(a_men),
    .fetch_NOP(a_fnop), .decode_NOP(a_dnop), .exe_NOP(a_enop), .fwdA(a_fwda), .fwdB(a_fwdb),
    .mem_timeout(a_to), .stall_cnt(a_cnt), .dbg_state(a_st)
  );

  hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(3)) u_b (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .MemRd(MemRd), .MemWr(MemWr),
    .PCSrc(PCSrc), .rs(rs), .rt(rt), .exe_wsel(exe_wsel), .mem_wsel(mem_wsel),
    .exe_RegWr(exe_RegWr), .mem_RegWr(mem_RegWr), .exe_MemRd(exe_MemRd),
    .PCWE(b_pcwe), .fetch_EN(b_fen), .decode_EN(b_den), .exe_EN(b_een), .mem_EN(b_men),
    .fetch_NOP(b_fnop), .decode_NOP(b_dnop), .exe_NOP(b_enop), .fwdA(b_fwda), .fwdB(b_fwdb),
    .mem_timeout(b_to), .stall_cnt(b_cnt), .dbg_state(b_st)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  // Driver tasks
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; MemRd = 1'b0; MemWr = 1'b0; PCSrc = 2'b00;
    rs = '0; rt = '0; exe_wsel = '0; mem_wsel = '0;
    exe_RegWr = 1'b0; mem_RegWr = 1'b0; exe_MemRd = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle();
    nxt();
    nxt();
    nRST = 1'b1;
  endtask

  // Comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0;
    idle();

    // Reset held 3 cycles with ihit high: everything forced inactive.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pcwe", {31'd0, a_pcwe}, 32'd0);
    chk("rst_en", {28'd0, a_fen, a_den, a_een, a_men}, 32'd0);
    chk("rst_cnt", {16'd0, a_cnt}, 32'd0);
    chk("rst_fwd", {28'd0, a_fwda, a_fwdb}, 32'd0);
    chk("rst_state", {30'd0, a_st}, 32'd0);
    nRST = 1'b1;
    #1;
    chk("run_pcwe", {31'd0, a_pcwe}, 32'd1);
    chk("run_en", {28'd0, a_fen, a_den, a_een, a_men}, 32'hF);
    chk("run_nop", {29'd0, a_fnop, a_dnop, a_enop}, 32'd0);
    chk("run_cnt", {16'd0, a_cnt}, 32'd0);

    // Taken branch, 3-cycle flush on u_a, single-cycle on u_b.
    PCSrc = 2'b01;
    #1;
    chk("fl1_nop_a", {29'd0, a_fnop, a_dnop, a_enop}, 32'h7);
    chk("fl1_en_a", {27'd0, a_pcwe, a_fen, a_den, a_een, a_men}, 32'h1F);
    chk("fl1_nop_b", {29'd0, b_fnop, b_dnop, b_enop}, 32'h7);
    nxt();
    PCSrc = 2'b00;
    #1;
    chk("fl2_state_a", {30'd0, a_st}, 32'd2);
    chk("fl2_nop_a", {29'd0, a_fnop, a_dnop, a_enop}, 32'h6);
    chk("fl2_state_b", {30'd0, b_st}, 32'd0);
    chk("fl2_nop_b", {29'd0, b_fnop, b_dnop, b_enop}, 32'h0);
    nxt();
    chk("fl3_nop_a", {29'd0, a_fnop, a_dnop, a_enop}, 32'h6);
    nxt();
    chk("fl4_state_a", {30'd0, a_st}, 32'd0);
    chk("fl4_nop_a", {29'd0, a_fnop, a_dnop, a_enop}, 32'h0);
    chk("fl4_cnt_a", {16'd0, a_cnt}, 32'd0);

    // Redirect inside FLUSH reloads the window.
    PCSrc = 2'b10;
    nxt();
    PCSrc = 2'b00;
    nxt();
    PCSrc = 2'b11;
    nxt();
    PCSrc = 2'b00;
    #1;
    chk("reload_flush_a", {30'd0, a_st}, 32'd2);
    nxt();
    nxt();
    chk("reload_run_a", {30'd0, a_st}, 32'd0);

    // Data-memory wait: dhit after 5 cycles; u_b watchdog at 4 MEMWAIT cycles.
    do_reset();
    MemRd = 1'b1;
    #1;
    chk("mw1_ctl", {27'd0, a_pcwe, a_fen, a_den, a_een, a_men}, 32'd0);
    nxt();
    chk("mw2_state", {30'd0, a_st}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("mw_ctl", {27'd0, a_pcwe, a_fen, a_den, a_een, a_men}, 32'd0);
      chk("mw_to_b", {31'd0, b_to}, 32'd0);
      nxt();
    end
    dhit = 1'b1;
    #1;
    chk("mw6_ctl", {27'd0, a_pcwe, a_fen, a_den, a_een, a_men}, 32'h1F);
    chk("mw6_to_b", {31'd0, b_to}, 32'd1);
    chk("mw6_to_a", {31'd0, a_to}, 32'd0);
    nxt();
    MemRd = 1'b0;
    dhit = 1'b0;
    #1;
    chk("mw_done_state", {30'd0, a_st}, 32'd0);
    chk("mw_cnt_a", {16'd0, a_cnt}, 32'd5);
    chk("mw_cnt_b", {29'd0, b_cnt}, 32'd5);
    chk("mw_to_sticky_b", {31'd0, b_to}, 32'd1);

    // Memory write completing at once takes effect even without ihit.
    ihit = 1'b0; MemWr = 1'b1; dhit = 1'b1;
    #1;
    chk("memwr_hit", {27'd0, a_pcwe, a_fen, a_den, a_een, a_men}, 32'h1F);
    nxt();
    idle();

    // RAW on rt against EX.
    do_reset();
    rt = 5'd5; exe_wsel = 5'd5; exe_RegWr = 1'b1;
    #1;
    chk("rawt_pcwe", {31'd0, a_pcwe}, FWD ? 32'd1 : 32'd0);
    chk("rawt_dnop", {31'd0, a_dnop}, FWD ? 32'd0 : 32'd1);
    chk("rawt_en", {28'd0, a_fen, a_den, a_een, a_men}, FWD ? 32'hF : 32'h3);
    nxt();
    rt = '0; exe_RegWr = 1'b0; exe_wsel = '0;
    #1;
    chk("rawt_fwdb", {30'd0, a_fwdb}, FWD ? 32'd1 : 32'd0);
    chk("rawt_fwda", {30'd0, a_fwda}, 32'd0);
    chk("rawt_cnt", {16'd0, a_cnt}, FWD ? 32'd0 : 32'd1);
    chk("rawt_clear", {31'd0, a_pcwe}, 32'd1);

    // RAW on rs against MEM.
    rs = 5'd9; mem_wsel = 5'd9; mem_RegWr = 1'b1;
    #1;
    chk("rawm_pcwe", {31'd0, a_pcwe}, FWD ? 32'd1 : 32'd0);
    nxt();
    chk("rawm_fwda", {30'd0, a_fwda}, FWD ? 32'd2 : 32'd0);

    // EX and MEM both match rs: EX wins.
    rs = 5'd3; exe_wsel = 5'd3; exe_RegWr = 1'b1; mem_wsel = 5'd3; mem_RegWr = 1'b1;
    nxt();
    chk("prio_fwda", {30'd0, a_fwda}, FWD ? 32'd1 : 32'd0);

    // Load-use: one stall, then the load result comes from MEM.
    do_reset();
    rs = 5'd7; exe_wsel = 5'd7; exe_RegWr = 1'b1; exe_MemRd = 1'b1;
    #1;
    chk("lu_pcwe", {31'd0, a_pcwe}, 32'd0);
    chk("lu_dnop", {31'd0, a_dnop}, 32'd1);
    nxt();
    exe_RegWr = 1'b0; exe_MemRd = 1'b0; exe_wsel = '0; mem_wsel = 5'd7; mem_RegWr = 1'b1;
    #1;
    chk("lu_fwda_bubble", {30'd0, a_fwda}, 32'd0);
    chk("lu2_pcwe", {31'd0, a_pcwe}, FWD ? 32'd1 : 32'd0);
    nxt();
    chk("lu_fwda_mem", {30'd0, a_fwda}, FWD ? 32'd2 : 32'd0);
    chk("lu_cnt", {16'd0, a_cnt}, FWD ? 32'd1 : 32'd2);

    // Register 0 never creates a dependency.
    rs = '0; exe_wsel = '0; exe_RegWr = 1'b1; mem_RegWr = 1'b0; mem_wsel = '0;
    #1;
    chk("r0_pcwe", {31'd0, a_pcwe}, 32'd1);
    chk("r0_dnop", {31'd0, a_dnop}, 32'd0);
    nxt();
    chk("r0_fwda", {30'd0, a_fwda}, 32'd0);

    // Reset asserted in the middle of MEMWAIT aborts to RUN at once.
    do_reset();
    MemRd = 1'b1;
    nxt();
    nxt();
    chk("mid_mw_state", {30'd0, a_st}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("mid_mw_rst_state", {30'd0, a_st}, 32'd0);
    chk("mid_mw_rst_cnt", {16'd0, a_cnt}, 32'd0);
    chk("mid_mw_rst_ctl", {27'd0, a_pcwe, a_fen, a_den, a_een, a_men}, 32'd0);

    // Reset asserted in the middle of FLUSH.
    do_reset();
    PCSrc = 2'b01;
    nxt();
    PCSrc = 2'b00;
    nRST = 1'b0;
    #1;
    chk("mid_fl_rst_state", {30'd0, a_st}, 32'd0);
    chk("mid_fl_rst_nop", {29'd0, a_fnop, a_dnop, a_enop}, 32'd0);

    // Stall counter saturation: ten cycles with no fetch.
    do_reset();
    ihit = 1'b0;
    repeat (10) nxt();
    chk("sat_cnt_a", {16'd0, a_cnt}, 32'd10);
    chk("sat_cnt_b", {29'd0, b_cnt}, 32'd7);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised, stateful successor to the pipeline hazard unit for the 5-stage MIPS datapath. Sits beside the four pipeline latches and the PC. It arbitrates four things:
- branch/jump flushes, including multi-cycle flush windows;
- data-memory wait stalls, with a wait-cycle watchdog;
- read-after-write stalls on both source operands;
- optional registered forwarding selects.

It keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_W, 5: register-select width
- FLUSH_CYCLES, 1: cycles of fetch/decode NOP insertion after a taken PCSrc (>=1)
- MEM_TIMEOUT, 64: MEMWAIT cycles before mem_timeout sets; 0 disables the watchdog
- CNT_W, 16: stall counter width

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete
- dhit  in  1  data access complete
- MemRd, MemWr  in  1 each  MEM-stage data request
- PCSrc  in  2  nonzero = taken branch/jump
- rs, rt  in  REG_W each  DECODE-stage source registers
- exe_wsel, mem_wsel  in  REG_W each  EX/MEM-stage destination registers
- exe_RegWr, mem_RegWr  in  1 each  EX/MEM-stage instruction writes a register
- exe_MemRd  in  1  EX-stage instruction is a load
- PCWE  out  1  PC write enable
- fetch_EN, decode_EN, exe_EN, mem_EN  out  1 each  latch enables
- fetch_NOP, decode_NOP, exe_NOP  out  1 each  latch bubble inserts
- fwdA, fwdB  out  2 each  operand source for the EX stage: 00 regfile, 01 EX/MEM latch, 10 MEM/WB latch
- mem_timeout  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  saturating stall-cycle count

## Operation
State machine with states RUN, MEMWAIT, FLUSH; reset state is RUN.

Per-cycle defaults: all EN=0, all NOP=0, PCWE=ihit.

RUN evaluates in priority order:
1. **PCSrc!=0:** fetch/decode/exe_NOP=1, all EN=1, PCWE=1. Go to FLUSH with flush_cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1; otherwise stay in RUN.
2. **(MemRd|MemWr) & dhit:** all EN=1, PCWE=1.
3. **(MemRd|MemWr) & !dhit:** all EN=0, PCWE=0. Go to MEMWAIT and clear wait_cnt.
4. **RAW stall:** PCWE=0, decode_NOP=1, exe_EN=mem_EN=1, fetch_EN=decode_EN=0.
5. **ihit:** all EN=1.

RAW matching:
- A source matches a stage when src==wsel, the stage's RegWr=1 and src!=0.
- rs and rt are checked independently.

MEMWAIT:
- All EN=0, PCWE=0, wait_cnt++.
- On dhit: all EN=1, PCWE=1, return to RUN.
- When wait_cnt reaches MEM_TIMEOUT (nonzero), set mem_timeout; it stays set until reset. The state is not left on timeout.

FLUSH:
- fetch_NOP=decode_NOP=1, EN=ihit, flush_cnt--.
- Return to RUN when flush_cnt==0 at the end of the cycle.
- A new PCSrc!=0 in FLUSH reloads flush_cnt.

stall_cnt:
- Increments each cycle PCWE=0 while nRST is high.
- Saturates at all-ones.

## Timing
- All control outputs are Mealy-combinational from the current state and inputs, with zero-cycle latency.
- fwdA/fwdB are registered. They load on the edge where decode_EN=1 and decode_NOP=0.
- fwd load rules:
  - rs matches EX → 01;
  - else rs matches MEM → 10;
  - else 00;
  - same rules for rt into fwdB;
  - EX has priority over MEM.
- fwd clear/hold rules:
  - Clear to 00 on any edge with decode_NOP=1 or exe_NOP=1.
  - Hold when exe_EN=0.
- While nRST=0: state=RUN, counters=0, fwdA=fwdB=00, mem_timeout=0, stall_cnt=0; all EN, NOP and PCWE forced to 0.
- Reset asserted mid-MEMWAIT or mid-FLUSH aborts to RUN immediately.

## Configuration
- HAZARD_FORWARD_EN defined:
  - RAW stall (RUN rule 4) fires only for a load-use case: exe_MemRd=1 and an EX match.
  - All other RAW dependencies are resolved through fwdA/fwdB.
- Undefined:
  - Any EX or MEM match stalls.
  - fwdA/fwdB are tied to 00 and their registers are omitted.

## Test plan
- Reset held 3 cycles, then released with ihit=1 and no hazards → PCWE=1, all EN=1, stall_cnt=0.
- PCSrc=01 with FLUSH_CYCLES=3 → fetch/decode_NOP high for 3 cycles, exe_NOP high only in the first; state returns to RUN on cycle 4.
- MemRd=1 with dhit arriving after 5 cycles → PCWE=0 and EN=0 for 5 cycles, all EN=1 on the dhit cycle, stall_cnt=5. Repeat with MEM_TIMEOUT=4 → mem_timeout sets after 4 wait cycles and stays set after dhit.
- rt=5, exe_wsel=5, exe_RegWr=1, rs=0:
  - Forwarding off → one stall cycle with decode_NOP=1.
  - Forwarding on → no stall; fwdB=01 after the advance.
- Forwarding on, exe_MemRd=1, rs=exe_wsel=7 → exactly one stall; next cycle rs matches MEM → fwdA=10.
- rs=0, exe_wsel=0, exe_RegWr=1 → no stall, fwdA=00.
